uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 CLOCK_FREQ, default 125_000_000, clk frequency in Hz.
REQ-002 BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  byte to transmit; sampled only on acceptance.
REQ-006 data_in_valid  input  1  producer has a byte on data_in.
REQ-007 data_in_ready  output  1  transmitter can accept a byte this cycle.
REQ-008 serial_out  output  1  UART line; idle high; drives the host-side RX pin.

Function
REQ-009 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-010 SYMBOL_EDGE_TIME SHALL equal CLOCK_FREQ / BAUD_RATE (integer division); every start and data bit lasts exactly SYMBOL_EDGE_TIME cycles, and the stop bit lasts at least SYMBOL_EDGE_TIME cycles.
REQ-011 Baud counter width SHALL be clog2(SYMBOL_EDGE_TIME)+1 bits; the counter restarts at 0 at every bit boundary with no cumulative drift.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; transitions are IDLE->START on accept, START->DATA after one bit time, DATA->STOP after bit 7, and STOP->IDLE after one bit time.
REQ-013 data_in_ready SHALL be 1 in IDLE only and 0 in START, DATA, and STOP.
REQ-014 A byte is accepted on the rising edge where data_in_valid and data_in_ready are both 1; data_in is latched into a shift register on that edge.
REQ-015 Accept at edge t0: serial_out=0 for cycles t0+1..t0+SET; bit i drives cycles t0+1+(i+1)*SET..t0+(i+2)*SET; the stop bit is 1 from t0+1+9*SET through at least t0+10*SET.
REQ-016 data_in_ready SHALL return to 1 at cycle t0+10*SET+1; a byte held valid there is accepted, giving back-to-back frames with exactly one extra idle-high cycle.
REQ-017 Changes to data_in or data_in_valid after acceptance SHALL NOT affect the frame in progress.
REQ-018 serial_out SHALL be driven directly from a flip-flop, with no combinational path from any input.
REQ-019 In IDLE with data_in_valid=0, serial_out SHALL remain 1 indefinitely.

Reset
REQ-020 While rst=1: serial_out=1, data_in_ready=0, FSM=IDLE, baud counter=0, bit index=0.
REQ-021 data_in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-022 If rst is asserted mid-frame, the frame SHALL be aborted, serial_out SHALL be 1 from the next cycle, and the abandoned byte SHALL never be resumed.
REQ-023 rst and data_in_valid asserted in the same cycle: reset wins and no byte is accepted.

Structure
REQ-024 A shared uart_pkg SHALL hold the FSM state encoding, START_BIT=0, STOP_BIT=1, and DATA_BITS=8, and SHALL be reused by the existing receiver.
REQ-025 SYMBOL_EDGE_TIME and the counter width SHALL be localparams derived inside the module, not package constants.
REQ-026 One sub-module, uart_baud_tick, SHALL implement the restartable bit-period counter and emit a one-cycle tick at the end of each bit; the FSM and shift register SHALL live in uart_transmitter.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so SET=10, unless stated)
REQ-027 Send 0xA5 -> serial_out is 0,1,0,1,0,0,1,0,1,1 with 10 cycles per bit; ready is low for exactly 100 cycles after acceptance.
REQ-028 Hold valid with 0x00 then 0xFF -> two frames 101 cycles apart start-to-start; the second frame is 0, eight 1s, 1.
REQ-029 Assert rst at cycle 35 of a frame for 0x3C -> serial_out=1 next cycle and stays 1; ready=1 the cycle after rst drops; no residual bits appear.
REQ-030 Accept 0x81, then change data_in to 0x00 and toggle valid during the frame -> the transmitted bits match 0x81 exactly.
REQ-031 Use default parameters (SET=1085) to send 0x55 -> each bit measures 1085 cycles; a loopback into the existing uart receiver returns 0x55.
REQ-032 Assert rst=1 and valid=1 together, then release both -> no frame is sent and serial_out stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding
// and the 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter. It emits a one-cycle tick in the last cycle
// of every bit and wraps to zero on that tick, so bit boundaries never drift.
module uart_baud_tick #(
    parameter int SYMBOL_EDGE_TIME = 1085,
    parameter int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart || tick || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte interface. serial_out is a
// registered output that idles high.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam int IDX_W            = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 accept;
    logic                 tick;

    // Gated by rst so no byte can be accepted in a reset cycle.
    assign data_in_ready = (state == IDLE) && !rst;
    assign accept        = data_in_valid && data_in_ready;

    uart_baud_tick #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME),
        .CNT_W           (CNT_W)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && (bit_idx == LAST_IDX)) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // serial_out is updated on the same edge as the state change, so the line
    // level always matches the bit the FSM is currently timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            serial_out <= STOP_BIT;
            bit_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= data_in;
                        serial_out <= START_BIT;
                        bit_idx    <= '0;
                    end else begin
                        serial_out <= STOP_BIT;
                    end
                end
                START: begin
                    if (tick) begin
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            serial_out <= STOP_BIT;
                            bit_idx    <= '0;
                        end else begin
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                            bit_idx    <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    serial_out <= STOP_BIT;
                end
                default: begin
                    serial_out <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random and directed frames compared against a
// per-cycle line model, plus a default-rate instance decoded by a sampling receiver.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
    localparam int SETD       = 125_000_000 / 115_200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;

    logic       rst_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       ready_d;
    logic       serial_d;

    int checks   = 0;
    int failures = 0;

    logic line_rec [10*SETD];

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    uart_transmitter dut_def (
        .clk          (clk),
        .rst          (rst_d),
        .data_in      (data_d),
        .data_in_valid(valid_d),
        .data_in_ready(ready_d),
        .serial_out   (serial_d)
    );

    // Line level k cycles after acceptance for an 8N1 frame carrying b.
    function automatic logic expected_line(input logic [7:0] b, input int k, input int set);
        int bit_n;
        bit_n = k / set;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n-1];
        return 1'b1;
    endfunction

    // Entered at a negedge with data_in=b and valid=1 already driven.
    task automatic run_frame(input logic [7:0] b, input bit garble,
                             input bit chain_next, input logic [7:0] nxt);
        logic exp_bit;
        checks++;
        if (data_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept byte=%02h got=%b want=1", b, data_in_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 10*SET; k++) begin
            exp_bit = expected_line(b, k, SET);
            checks++;
            if (serial_out !== exp_bit) begin
                failures++;
                $display("FAIL serial_out byte=%02h k=%0d got=%b want=%b", b, k, serial_out, exp_bit);
            end
            checks++;
            if (data_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_busy byte=%02h k=%0d got=%b want=0", b, k, data_in_ready);
            end
            if (garble) begin
                data_in       = 8'($urandom);
                data_in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        checks++;
        if (data_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_frame byte=%02h got=%b want=1", b, data_in_ready);
        end
        checks++;
        if (serial_out !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_frame byte=%02h got=%b want=1", b, serial_out);
        end
        data_in_valid = chain_next;
        data_in       = nxt;
    endtask

    task automatic test_reset();
        checks++;
        if (serial_out !== 1'b1 || serial_d !== 1'b1) begin
            failures++;
            $display("FAIL reset_serial got=%b/%b want=1/1", serial_out, serial_d);
        end
        checks++;
        if (data_in_ready !== 1'b0 || ready_d !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b/%b want=0/0", data_in_ready, ready_d);
        end
        rst   = 1'b0;
        rst_d = 1'b0;
        @(negedge clk);
        checks++;
        if (data_in_ready !== 1'b1 || ready_d !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b/%b want=1/1", data_in_ready, ready_d);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle k=%0d serial=%b ready=%b want 1/1", k, serial_out, data_in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_a5();
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        run_frame(8'hA5, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        data_in = 8'h00;
        data_in_valid = 1'b1;
        run_frame(8'h00, 1'b0, 1'b1, 8'hFF);
        run_frame(8'hFF, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_input_change();
        data_in = 8'h81;
        data_in_valid = 1'b1;
        run_frame(8'h81, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            data_in = b;
            data_in_valid = 1'b1;
            run_frame(b, n[0], 1'b0, 8'h00);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic exp_bit;
        data_in = 8'h3C;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int k = 0; k <= 35; k++) begin
            exp_bit = expected_line(8'h3C, k, SET);
            checks++;
            if (serial_out !== exp_bit) begin
                failures++;
                $display("FAIL pre_abort k=%0d got=%b want=%b", k, serial_out, exp_bit);
            end
            if (k < 35) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || data_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort serial=%b ready=%b want 1/0", serial_out, data_in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (data_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_abort got=%b want=1", data_in_ready);
        end
        for (int k = 0; k < 12*SET; k++) begin
            checks++;
            if (serial_out !== 1'b1) begin
                failures++;
                $display("FAIL residual_bit k=%0d got=%b want=1", k, serial_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_with_valid();
        rst = 1'b1;
        data_in = 8'($urandom);
        data_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || data_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid serial=%b ready=%b want 1/0", serial_out, data_in_ready);
        end
        rst = 1'b0;
        data_in_valid = 1'b0;
        for (int k = 0; k < 15*SET; k++) begin
            @(negedge clk);
            checks++;
            if (serial_out !== 1'b1) begin
                failures++;
                $display("FAIL rst_valid_frame k=%0d got=%b want=1", k, serial_out);
            end
        end
    endtask

    task automatic test_default_rate();
        int         bad;
        int         busy_bad;
        logic [7:0] rx;
        data_d  = 8'h55;
        valid_d = 1'b1;
        checks++;
        if (ready_d !== 1'b1) begin
            failures++;
            $display("FAIL def_ready_before got=%b want=1", ready_d);
        end
        @(negedge clk);
        valid_d  = 1'b0;
        busy_bad = 0;
        for (int k = 0; k < 10*SETD; k++) begin
            line_rec[k] = serial_d;
            if (ready_d !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        checks++;
        if (busy_bad != 0 || ready_d !== 1'b1) begin
            failures++;
            $display("FAIL def_ready busy_errs=%0d end_ready=%b want 0/1", busy_bad, ready_d);
        end
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int j = 0; j < SETD; j++) begin
                if (line_rec[i*SETD+j] !== expected_line(8'h55, i*SETD+j, SETD)) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL def_bit_length bit=%0d wrong_cycles=%0d want=0", i, bad);
            end
        end
        for (int i = 0; i < 8; i++) rx[i] = line_rec[(i+1)*SETD + SETD/2];
        checks++;
        if (line_rec[SETD/2] !== 1'b0 || line_rec[9*SETD + SETD/2] !== 1'b1 || rx !== 8'h55) begin
            failures++;
            $display("FAIL def_loopback start=%b stop=%b data=%02h want 0/1/55",
                     line_rec[SETD/2], line_rec[9*SETD + SETD/2], rx);
        end
    endtask

    initial begin
        rst           = 1'b1;
        rst_d         = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        data_d        = 8'h00;
        valid_d       = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_idle();
        test_a5();
        test_back_to_back();
        test_input_change();
        test_random();
        test_mid_reset();
        test_rst_with_valid();
        test_default_rate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
